// File: rtl/exu_issue_ctrl_pkg.sv
// exu_issue_ctrl_pkg: shared state encoding and status bundle for the EX issue controller.
package exu_issue_ctrl_pkg;
    localparam int STATUS_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT_MC
    } exu_ctrl_state_t;

    typedef struct packed {
        logic                    timeout_err;
        logic [STATUS_CNT_W-1:0] mc_stall_cnt;
    } exu_ctrl_status_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clr together with inc restarts at 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else if (i_clr) r_cnt <= W'(i_inc);
        else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/exu_issue_ctrl.sv
// exu_issue_ctrl: owns the EX valid bit, holds operands across multicycle ops,
// gates EX/WB capture on backpressure and times redirects and exceptions.
module exu_issue_ctrl
    import exu_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_dec_valid,
    output logic             o_dec_ready,
    output logic             o_exu_fire,
    output logic             o_exu_op_valid,
    input  logic             i_exu_busy,
    input  logic             i_exu_is_bj,
    input  logic             i_exu_redirect_valid,
    input  logic             i_exu_except,
    output logic             o_wb_capture,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic             o_redirect_fire,
    output logic             o_timeout_err,
    output logic [CNT_W-1:0] o_mc_stall_cnt
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    exu_ctrl_state_t   r_state, w_next;
    logic              r_wb_valid, r_timeout;
    logic              w_in_wait, w_done, w_slot_free, w_capture, w_take_bj;
    logic              w_dec_ready, w_fire, w_wait_clr, w_wait_inc;
    logic [WAIT_W-1:0] w_wait_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    // A busy EXU never completes, so a fire can only come from IDLE or a completion.
    always_comb begin
        w_next = i_flush ? IDLE :
                 w_fire ? EXEC :
                 (r_state != IDLE && i_exu_busy) ? WAIT_MC :
                 w_capture ? IDLE : r_state;
    end

    always_comb begin
        w_in_wait   = r_state == WAIT_MC;
        w_done      = r_state != IDLE && !i_exu_busy;
        w_slot_free = !r_wb_valid || i_wb_ready;
        w_capture   = !i_flush && w_done && w_slot_free;
        w_take_bj   = w_capture && i_exu_redirect_valid && i_exu_is_bj;
        w_dec_ready = !i_flush && (r_state == IDLE || (w_capture && !w_take_bj && !i_exu_except));
        w_fire      = w_dec_ready && i_dec_valid;
        w_wait_clr  = i_flush || !w_in_wait;
        w_wait_inc  = !i_flush && (w_in_wait || (r_state == EXEC && i_exu_busy));
    end

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_wait_clr),
        .i_inc   (w_wait_inc),
        .o_cnt   (w_wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (1'b0),
        .i_inc   (w_in_wait),
        .o_cnt   (o_mc_stall_cnt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_valid <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_wb_valid <= !i_flush && (w_capture || (r_wb_valid && !i_wb_ready));
            r_timeout  <= r_timeout || (w_in_wait && w_wait_cnt >= WAIT_W'(TIMEOUT_CYCLES));
        end
    end

    // Handshake strobes are held low while reset is asserted, even though IDLE is ready.
    assign o_dec_ready     = w_dec_ready && i_rst_n;
    assign o_exu_fire      = w_fire && i_rst_n;
    assign o_exu_op_valid  = r_state != IDLE;
    assign o_wb_capture    = w_capture;
    assign o_wb_valid      = r_wb_valid;
    assign o_redirect_fire = w_take_bj;
    assign o_timeout_err   = r_timeout;
endmodule

// File: tb/tb_exu_issue_ctrl.sv
// tb_exu_issue_ctrl: randomized and directed checks of exu_issue_ctrl against an
// op-age model of the EX stage.
module tb_exu_issue_ctrl;
    localparam int TO = 64;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, dec_valid = 1'b0, exu_busy = 1'b0;
    logic exu_is_bj = 1'b0, exu_redirect_valid = 1'b0, exu_except = 1'b0, wb_ready = 1'b0;
    logic dec_ready, exu_fire, exu_op_valid, wb_capture, wb_valid, redirect_fire, timeout_err;
    logic [31:0] mc_stall_cnt;

    int checks = 0, errors = 0;
    bit m_live, m_wbv, m_to, m_bj, m_rv, m_ex;
    int m_age, m_lat;
    longint m_stall;
    int nx_lat;
    bit nx_bj, nx_rv, nx_ex, rand_on, g_busy;
    int pv = 70, pr = 60, pf = 2;
    bit s_dr, s_fire, s_cap, s_rf, s_opv, s_to;
    int n_fire, n_cap, n_dr, n_wbv, n_opv;

    always #5 clk = ~clk;

    exu_issue_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_flush              (flush),
        .i_dec_valid          (dec_valid),
        .o_dec_ready          (dec_ready),
        .o_exu_fire           (exu_fire),
        .o_exu_op_valid       (exu_op_valid),
        .i_exu_busy           (exu_busy),
        .i_exu_is_bj          (exu_is_bj),
        .i_exu_redirect_valid (exu_redirect_valid),
        .i_exu_except         (exu_except),
        .o_wb_capture         (wb_capture),
        .o_wb_valid           (wb_valid),
        .i_wb_ready           (wb_ready),
        .o_redirect_fire      (redirect_fire),
        .o_timeout_err        (timeout_err),
        .o_mc_stall_cnt       (mc_stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pick_op();
        nx_lat = ($urandom_range(3) == 0) ? int'($urandom_range(1, 8)) : 0;
        if ($urandom_range(19) == 0) nx_lat = int'($urandom_range(60, 75));
        nx_bj = $urandom_range(3) == 0;
        nx_rv = $urandom_range(1) == 1;
        nx_ex = $urandom_range(7) == 0;
    endtask

    task automatic set_op(input int lat, input bit bj, input bit rv, input bit ex);
        nx_lat = lat; nx_bj = bj; nx_rv = rv; nx_ex = ex;
    endtask

    task automatic clr_counts();
        n_fire = 0; n_cap = 0; n_dr = 0; n_wbv = 0; n_opv = 0;
    endtask

    // One cycle: drive at negedge (the bench plays the EXU), compare mid-cycle, advance the model.
    task automatic step(input int dv, input int wr, input int fl);
        bit busy, sf, done, e_cap, e_rf, e_dr, e_fire, in_wait;
        @(negedge clk);
        dec_valid = (dv < 0) ? ($urandom_range(99) < pv) : dv[0];
        wb_ready  = (wr < 0) ? ($urandom_range(99) < pr) : wr[0];
        flush     = (fl < 0) ? ($urandom_range(99) < pf) : fl[0];
        busy = m_live && m_age < m_lat;
        exu_busy = m_live ? busy : (rand_on ? ($urandom_range(3) == 0) : g_busy);
        exu_is_bj = m_live ? m_bj : ($urandom_range(1) == 1);
        exu_redirect_valid = m_live ? m_rv : ($urandom_range(1) == 1);
        exu_except = m_live ? m_ex : ($urandom_range(1) == 1);
        #2;
        sf     = !m_wbv || wb_ready;
        done   = m_live && !busy;
        e_cap  = !flush && done && sf;
        e_rf   = e_cap && m_rv && m_bj;
        e_dr   = !flush && (!m_live || (e_cap && !e_rf && !m_ex));
        e_fire = e_dr && dec_valid;
        chk("dec_ready", dec_ready, e_dr);
        chk("exu_fire", exu_fire, e_fire);
        chk("exu_op_valid", exu_op_valid, m_live);
        chk("wb_capture", wb_capture, e_cap);
        chk("redirect_fire", redirect_fire, e_rf);
        chk("wb_valid", wb_valid, m_wbv);
        chk("timeout_err", timeout_err, m_to);
        chk("mc_stall_cnt", mc_stall_cnt, m_stall);
        s_dr = dec_ready; s_fire = exu_fire; s_cap = wb_capture;
        s_rf = redirect_fire; s_opv = exu_op_valid; s_to = timeout_err;
        if (exu_fire) n_fire++;
        if (wb_capture) n_cap++;
        if (dec_ready) n_dr++;
        if (wb_valid) n_wbv++;
        if (exu_op_valid) n_opv++;
        in_wait = m_live && m_lat > 0 && m_age >= 1;
        if (in_wait) m_stall++;
        if (in_wait && m_age >= TO) m_to = 1'b1;
        m_wbv = !flush && (e_cap || (m_wbv && !wb_ready));
        if (flush || (e_cap && !e_fire)) m_live = 1'b0;
        else if (e_fire) begin
            m_live = 1'b1; m_age = 0; m_lat = nx_lat;
            m_bj = nx_bj; m_rv = nx_rv; m_ex = nx_ex;
            if (rand_on) pick_op();
        end else if (m_live) m_age++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; dec_valid = 1'b1; wb_ready = 1'b1; flush = 1'b0;
        #2;
        chk("rst_dec_ready", dec_ready, 0);
        chk("rst_exu_fire", exu_fire, 0);
        chk("rst_op_valid", exu_op_valid, 0);
        chk("rst_wb_capture", wb_capture, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_redirect", redirect_fire, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_stall_cnt", mc_stall_cnt, 0);
        m_live = 1'b0; m_wbv = 1'b0; m_to = 1'b0; m_stall = 0;
        @(negedge clk);
        dec_valid = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        int first_to, cap_at;
        rand_on = 1'b0; g_busy = 1'b0;
        do_reset();

        set_op(0, 0, 0, 0);
        clr_counts();
        repeat (3) step(1, 1, 0);
        repeat (3) step(0, 1, 0);
        chk("t1_fires", n_fire, 3);
        chk("t1_captures", n_cap, 3);
        chk("t1_wb_valid_cycles", n_wbv, 3);

        set_op(33, 0, 0, 0);
        step(1, 1, 0);
        clr_counts();
        repeat (33) step(0, 1, 0);
        chk("t2_dec_ready_in_wait", n_dr, 0);
        chk("t2_no_early_capture", n_cap, 0);
        step(0, 1, 0);
        chk("t2_capture_on_busy_fall", s_cap, 1);
        step(0, 1, 0);
        chk("t2_stall_cnt", mc_stall_cnt, 33);

        set_op(0, 0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        clr_counts();
        repeat (4) step(0, 0, 0);
        chk("t3_held_captures", n_cap, 0);
        chk("t3_held_op_valid", n_opv, 4);
        chk("t3_held_dec_ready", n_dr, 0);
        step(0, 1, 0);
        chk("t3_capture_on_ready", s_cap, 1);
        step(0, 1, 0);

        set_op(0, 1, 1, 0);
        step(1, 1, 0);
        set_op(0, 0, 0, 0);
        step(1, 1, 0);
        chk("t4_redirect", s_rf, 1);
        chk("t4_capture", s_cap, 1);
        chk("t4_dec_ready", s_dr, 0);
        chk("t4_no_young_fire", s_fire, 0);
        step(1, 1, 0);
        chk("t4_idle_after", s_opv, 0);
        step(0, 1, 0);
        step(0, 1, 0);

        step(1, 0, 0);
        set_op(20, 0, 0, 0);
        step(1, 0, 0);
        repeat (5) step(0, 0, 0);
        step(0, 0, 1);
        chk("t5_flush_no_capture", s_cap, 0);
        g_busy = 1'b1;
        clr_counts();
        repeat (3) step(0, 1, 0);
        g_busy = 1'b0;
        chk("t5_glitch_op_valid", n_opv, 0);
        chk("t5_wb_valid_cleared", n_wbv, 0);

        set_op(70, 0, 0, 0);
        step(1, 1, 0);
        first_to = -1; cap_at = -1;
        for (int k = 0; k <= 70; k++) begin
            step(0, 1, 0);
            if (s_to && first_to < 0) first_to = k;
            if (s_cap && cap_at < 0) cap_at = k;
        end
        chk("t6_timeout_visible", first_to, 65);
        chk("t6_completion", cap_at, 70);
        step(0, 1, 0);
        chk("t6_stall_total", mc_stall_cnt, 108);

        rand_on = 1'b1;
        pick_op();
        repeat (3000) step(-1, -1, -1);
        chk("timeout_sticky", timeout_err, 1);

        do_reset();
        chk("timeout_cleared", timeout_err, 0);
        repeat (500) step(-1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
